// File: rtl/stack_pkg.sv
//------------------------------------------------------------------------------
// Module      : stack_pkg
// Description : Shared defaults, interface widths and operation decode codes
//               for the hardware LIFO stack.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package stack_pkg;

    localparam int STK_DATA_WIDTH  = 8;
    localparam int STK_DEPTH       = 16;
    localparam int STK_COUNT_WIDTH = $clog2(STK_DEPTH) + 1;

    localparam logic [2:0] OP_IDLE           = 3'd0;
    localparam logic [2:0] OP_PUSH           = 3'd1;
    localparam logic [2:0] OP_POP            = 3'd2;
    localparam logic [2:0] OP_REPLACE        = 3'd3;
    localparam logic [2:0] OP_PUSH_EMPTY_POP = 3'd4;
    localparam logic [2:0] OP_REJECT_PUSH    = 3'd5;
    localparam logic [2:0] OP_REJECT_POP     = 3'd6;

endpackage

`default_nettype wire

// File: rtl/stack_mem.sv
//------------------------------------------------------------------------------
// Module      : stack_mem
// Description : DEPTH x DATA_WIDTH register file, one synchronous write port
//               and one asynchronous read port, no reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stack_mem
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = STK_DATA_WIDTH,
    parameter int DEPTH      = STK_DEPTH,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/hw_stack.sv
//------------------------------------------------------------------------------
// Module      : hw_stack
// Description : LIFO data stack with registered pop data, full/empty/count,
//               sticky overflow/underflow flags and a top-of-stack peek.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hw_stack
    import stack_pkg::*;
#(
    parameter  int DATA_WIDTH = STK_DATA_WIDTH,
    parameter  int DEPTH      = STK_DEPTH,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] top,
    output logic                  full,
    output logic                  empty,
    output logic [AW:0]           count,
    output logic                  overflow,
    output logic                  underflow
);

    // sp never wraps, so the next-free pointer and the occupancy are one register.
    logic [AW:0]           sp_q, sp_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic [2:0]            op;
    logic [AW-1:0]         top_addr;
    logic [AW-1:0]         waddr;
    logic                  we;
    logic [DATA_WIDTH-1:0] rdata;

    assign full     = (sp_q == (AW+1)'(DEPTH));
    assign empty    = (sp_q == '0);
    assign top_addr = sp_q[AW-1:0] - AW'(1);

    always_comb begin
        op = OP_IDLE;
        case ({push, pop})
            2'b10:   op = full  ? OP_REJECT_PUSH    : OP_PUSH;
            2'b01:   op = empty ? OP_REJECT_POP     : OP_POP;
            2'b11:   op = empty ? OP_PUSH_EMPTY_POP : OP_REPLACE;
            default: op = OP_IDLE;
        endcase
    end

    assign we    = (op == OP_PUSH) || (op == OP_REPLACE) || (op == OP_PUSH_EMPTY_POP);
    assign waddr = (op == OP_REPLACE) ? top_addr : sp_q[AW-1:0];

    always_comb begin
        sp_d   = sp_q;
        dout_d = dout_q;
        ovf_d  = clr_err ? 1'b0 : ovf_q;
        unf_d  = clr_err ? 1'b0 : unf_q;
        case (op)
            OP_PUSH: sp_d = sp_q + (AW+1)'(1);
            OP_POP: begin
                sp_d   = sp_q - (AW+1)'(1);
                dout_d = rdata;
            end
            OP_REPLACE:     dout_d = rdata;
            OP_PUSH_EMPTY_POP: begin
                sp_d  = sp_q + (AW+1)'(1);
                unf_d = 1'b1;
            end
            OP_REJECT_PUSH: ovf_d = 1'b1;
            OP_REJECT_POP:  unf_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q   <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            sp_q   <= sp_d;
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    stack_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (data_in),
        .raddr (top_addr),
        .rdata (rdata)
    );

    assign data_out  = dout_q;
    assign top       = empty ? '0 : rdata;
    assign count     = sp_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_hw_stack.sv
//------------------------------------------------------------------------------
// Module      : tb_hw_stack
// Description : Self-checking bench for hw_stack: vector table plus hand
//               sequences for fill/overflow and asynchronous reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hw_stack;

    localparam int DW = 8;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic [DW-1:0] top;
    logic          full;
    logic          empty;
    logic [4:0]    count;
    logic          overflow;
    logic          underflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         pu;
        bit         po;
        bit         cl;
        logic [7:0] din;
        int         cnt;
        logic [7:0] tp;
        bit         ov;
        bit         un;
        bit         pv;
        logic [7:0] pval;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] sb[$];
    logic [7:0] exp_dout = 8'h00;

    always #5 clk = ~clk;

    hw_stack #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .data_in   (data_in),
        .clr_err   (clr_err),
        .data_out  (data_out),
        .top       (top),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    function automatic vec_t mk(bit pu, bit po, bit cl, logic [7:0] din, int cnt,
                                logic [7:0] tp, bit ov, bit un, bit pv, logic [7:0] pval);
        vec_t v;
        v.pu = pu; v.po = po; v.cl = cl; v.din = din; v.cnt = cnt;
        v.tp = tp; v.ov = ov; v.un = un; v.pv = pv; v.pval = pval;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input int cnt, input logic [7:0] tp, input bit ov, input bit un);
        chk("count",     32'(count),     32'(cnt));
        chk("top",       32'(top),       32'(tp));
        chk("full",      32'(full),      32'(cnt == DP));
        chk("empty",     32'(empty),     32'(cnt == 0));
        chk("overflow",  32'(overflow),  32'(ov));
        chk("underflow", 32'(underflow), 32'(un));
        chk("data_out",  32'(data_out),  32'(exp_dout));
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        push    = v.pu;
        pop     = v.po;
        clr_err = v.cl;
        data_in = v.din;
        if (v.pv) sb.push_back(v.pval);
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        if (sb.size() > 0) exp_dout = sb.pop_front();
        check_all(v.cnt, v.tp, v.ov, v.un);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        exp_dout = 8'h00;
        #1;
        check_all(0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        // underflow from reset, then basic LIFO ordering
        tbl.push_back(mk(0,1,0,8'h00, 0,8'h00, 0,1, 0,8'h00));
        tbl.push_back(mk(0,1,1,8'h00, 0,8'h00, 0,1, 0,8'h00));
        tbl.push_back(mk(0,0,1,8'h00, 0,8'h00, 0,0, 0,8'h00));
        tbl.push_back(mk(1,0,0,8'h11, 1,8'h11, 0,0, 0,8'h00));
        tbl.push_back(mk(1,0,0,8'h22, 2,8'h22, 0,0, 0,8'h00));
        tbl.push_back(mk(1,0,0,8'h33, 3,8'h33, 0,0, 0,8'h00));
        tbl.push_back(mk(0,1,0,8'h00, 2,8'h22, 0,0, 1,8'h33));
        tbl.push_back(mk(0,1,0,8'h00, 1,8'h11, 0,0, 1,8'h22));
        tbl.push_back(mk(0,1,0,8'h00, 0,8'h00, 0,0, 1,8'h11));
        tbl.push_back(mk(0,1,0,8'h00, 0,8'h00, 0,1, 0,8'h00));
        tbl.push_back(mk(0,0,1,8'h00, 0,8'h00, 0,0, 0,8'h00));
        tbl.push_back(mk(1,1,0,8'h42, 1,8'h42, 0,1, 0,8'h00));
        tbl.push_back(mk(0,0,1,8'h00, 1,8'h42, 0,0, 0,8'h00));
        tbl.push_back(mk(0,0,0,8'hEE, 1,8'h42, 0,0, 0,8'h00));
        tbl.push_back(mk(0,1,0,8'h00, 0,8'h00, 0,0, 1,8'h42));
        tbl.push_back(mk(1,0,0,8'h05, 1,8'h05, 0,0, 0,8'h00));
        tbl.push_back(mk(1,0,0,8'h07, 2,8'h07, 0,0, 0,8'h00));
        tbl.push_back(mk(1,1,0,8'h09, 2,8'h09, 0,0, 1,8'h07));
        tbl.push_back(mk(0,1,0,8'h00, 1,8'h05, 0,0, 1,8'h09));
        tbl.push_back(mk(0,1,0,8'h00, 0,8'h00, 0,0, 1,8'h05));

        repeat (2) @(posedge clk);
        do_reset();

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // fill to full, overflow, clear, replace at full, set-wins on clear
        do_reset();
        for (int i = 0; i < DP; i++) apply(mk(1,0,0,8'(i), i+1, 8'(i), 0,0, 0,8'h00));
        apply(mk(1,0,0,8'hAA, 16,8'h0F, 1,0, 0,8'h00));
        apply(mk(0,0,1,8'h00, 16,8'h0F, 0,0, 0,8'h00));
        apply(mk(1,1,0,8'h99, 16,8'h99, 0,0, 1,8'h0F));
        apply(mk(1,0,1,8'hBB, 16,8'h99, 1,0, 0,8'h00));
        apply(mk(0,1,0,8'h00, 15,8'h0E, 1,0, 1,8'h99));

        // asynchronous reset between edges while a pop is pending
        do_reset();
        apply(mk(1,0,0,8'h10, 1,8'h10, 0,0, 0,8'h00));
        apply(mk(1,0,0,8'h20, 2,8'h20, 0,0, 0,8'h00));
        apply(mk(0,1,0,8'h00, 1,8'h10, 0,0, 1,8'h20));
        @(negedge clk);
        pop = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        sb.delete();
        exp_dout = 8'h00;
        check_all(0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        pop   = 1'b0;
        #1;
        check_all(0, 8'h00, 1'b0, 1'b0);
        apply(mk(1,0,0,8'h55, 1,8'h55, 0,0, 0,8'h00));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hw_stack.md
Name: hw_stack

Overview:
- LIFO data stack serving the multicycle stack processor's push/pop interface. It is the responder end of that interface.
- The processor drives push, pop and write data; this block returns popped data one cycle later and reports full/empty.
- Adds sticky overflow/underflow error flags, an occupancy count and a combinational top-of-stack peek for debug and for the seven-segment display path.

Parameters:
DATA_WIDTH, 8, width of each stack entry
DEPTH, 16, number of entries (power of two, >= 2)
AW, $clog2(DEPTH), internal pointer width (derived, not overridden)

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
push  input  1  push request, sampled at rising clk
pop  input  1  pop request, sampled at rising clk
data_in  input  DATA_WIDTH  value to push (processor's stack_data_out)
clr_err  input  1  synchronous clear of sticky error flags
data_out  output  DATA_WIDTH  registered popped value (processor's stack_data_in)
top  output  DATA_WIDTH  combinational peek of current top entry; 0 when empty
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  AW+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: push attempted while full and not accepted
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, active-high): sp=0, count=0, data_out=0, overflow=0, underflow=0, so empty=1 and full=0. Memory contents are not reset; no check may depend on them.
- sp indexes the next free slot; the top entry is mem[sp-1]. full and empty are decoded combinationally from count.
- Push only (push=1, pop=0):
  - Not full: mem[sp]<=data_in; sp++, count++.
  - Full: write dropped, state unchanged, overflow<=1.
- Pop only (push=0, pop=1):
  - Not empty: data_out<=mem[sp-1]; sp--, count--. Popped data is visible on data_out in the cycle after pop is sampled (1-cycle latency).
  - Empty: data_out holds its previous value, state unchanged, underflow<=1.
- Push and pop together:
  - Not empty (including full): data_out<=old top; mem[sp-1]<=data_in (replace top); sp and count unchanged; no overflow.
  - Empty: push performed (count becomes 1), pop ignored, underflow<=1, data_out holds.
- Neither asserted: all registers hold. data_out holds its last popped value indefinitely.
- Error flags:
  - clr_err=1 clears overflow and underflow on that edge.
  - If an error event occurs in the same cycle as clr_err, the flag sets (set wins).
  - Flags never affect stack operation.
- Wrap-around: sp never wraps. Push at count==DEPTH is the overflow case; pop at 0 is the underflow case.
- top = mem[sp-1] when count>0, else 0. It reflects the state after the most recent edge.
- Reset asserted mid-operation: immediately returns to the reset state; an in-flight push/pop in that cycle is discarded.
- Control state is the occupancy/pointer pair, plus an operation decode: IDLE, PUSH, POP, REPLACE, PUSH_EMPTY_POP, REJECT_PUSH, REJECT_POP. Each decode maps to one of the update rules above.

Decomposition:
- Shared package stack_pkg holds:
  - DATA_WIDTH and DEPTH defaults.
  - The operation-decode localparams (the seven names above, 3-bit encoding).
  - The shared interface widths used by the processor.
- One sub-module, stack_mem: DEPTH x DATA_WIDTH register file.
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
  - No reset.
- hw_stack owns sp, count, flags, data_out and the operation decode.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles -> count=3, top=0x33, empty=0. Then pop three times -> data_out 0x33, 0x22, 0x11, each one cycle after its pop; count=0, empty=1.
- Fill with DEPTH=16 pushes of 0x00..0x0F -> full=1, count=16. Push 0xAA -> overflow=1, count=16, top=0x0F. Then clr_err -> overflow=0.
- From empty, pop -> underflow=1, data_out unchanged (0 after reset), count=0. Assert clr_err together with another pop -> underflow stays 1.
- Stack holds 0x05, 0x07 (top); push=pop=1 with data_in=0x09 -> data_out=0x07, top=0x09, count=2. Repeat at full -> no overflow, count=16.
- From empty, push=pop=1 with data_in=0x42 -> count=1, top=0x42, underflow=1, data_out unchanged.
- Push 0x10 and 0x20, assert reset asynchronously between clock edges during a pop -> all outputs return to reset values immediately (empty=1, count=0, data_out=0, flags 0). First push after release is accepted normally.
